// File: rtl/prog_mem_exec_pkg.sv
// Shared definitions for the command-program executor: widths, opcodes,
// event bit positions, reserved time-word addresses and small decode helpers.
package prog_mem_exec_pkg;

  localparam int DW   = 16;
  localparam int AW   = 8;
  localparam int ACCW = 20;

  // First reserved time word; the program must end below it.
  localparam logic [AW-1:0] TBASE = 8'd250;

  // Time-of-day words written by the program source.
  localparam logic [AW-1:0] ADDR_DNI = 8'd250;
  localparam logic [AW-1:0] ADDR_H   = 8'd251;
  localparam logic [AW-1:0] ADDR_MIN = 8'd252;
  localparam logic [AW-1:0] ADDR_S   = 8'd253;

  // Opcodes (low byte of a program word).
  localparam logic [7:0] OP_TNO  = 8'h01;
  localparam logic [7:0] OP_TNC  = 8'h02;
  localparam logic [7:0] OP_TNI  = 8'h03;
  localparam logic [7:0] OP_TNP  = 8'h04;
  localparam logic [7:0] OP_TKI  = 8'h05;
  localparam logic [7:0] OP_TKP  = 8'h06;
  localparam logic [7:0] OP_DTNC = 8'h07;
  localparam logic [7:0] OP_DTNI = 8'h08;
  localparam logic [7:0] OP_DTNP = 8'h09;
  localparam logic [7:0] OP_DTKI = 8'h0A;
  localparam logic [7:0] OP_DTKP = 8'h0B;
  localparam logic [7:0] OP_DX0C = 8'h0C;
  localparam logic [7:0] OP_TOBM = 8'h0D;
  localparam logic [7:0] OP_DX0E = 8'h0E;
  localparam logic [7:0] OP_END  = 8'hFF;

  // Event strobe bit positions.
  localparam int EV_TNC  = 0;
  localparam int EV_TNI  = 1;
  localparam int EV_TNP  = 2;
  localparam int EV_TKI  = 3;
  localparam int EV_TKP  = 4;
  localparam int EV_TOBM = 5;

  localparam logic [2:0] TNO_OPERANDS = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_OPND   = 3'd3,
    ST_WAIT   = 3'd4,
    ST_STROBE = 3'd5
  } state_t;

  // One-hot event strobe for an event opcode, zero for anything else.
  function automatic logic [5:0] ev_mask(input logic [7:0] op);
    logic [5:0] m;
    case (op)
      OP_TNC:  m = 6'b00_0001;
      OP_TNI:  m = 6'b00_0010;
      OP_TNP:  m = 6'b00_0100;
      OP_TKI:  m = 6'b00_1000;
      OP_TKP:  m = 6'b01_0000;
      OP_TOBM: m = 6'b10_0000;
      default: m = 6'b00_0000;
    endcase
    return m;
  endfunction

  function automatic logic is_delay(input logic [7:0] op);
    return ((op >= OP_DTNC) && (op <= OP_DX0C)) || (op == OP_DX0E);
  endfunction

  function automatic logic is_event(input logic [7:0] op);
    return ((op >= OP_TNC) && (op <= OP_TKP)) || (op == OP_TOBM);
  endfunction

  // Delay accumulation that sticks at the all-ones value instead of wrapping.
  function automatic logic [ACCW-1:0] sat_add(input logic [ACCW-1:0] a,
                                               input logic [DW-1:0]   b);
    logic [ACCW:0] sum;
    sum = {1'b0, a} + {5'd0, b};
    if (sum[ACCW]) begin
      return {ACCW{1'b1}};
    end else begin
      return sum[ACCW-1:0];
    end
  endfunction

endpackage

// File: rtl/prog_mem_exec_ram.sv
// 256x16 program RAM: one write port, one synchronous read port.
// A read and write to the same address in one cycle returns the old word.
module prog_ram_256x16
  import prog_mem_exec_pkg::*;
(
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_r [0:(1<<AW)-1];
  logic [DW-1:0] rdata_r;

  // Write port, accepted in every cycle we is high.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read; non-blocking update gives old data on a collision.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata_r <= mem_r[raddr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/prog_mem_exec.sv
// Command-program executor: stores the streamed program, interprets it from
// address 0 on start, accumulates delays and emits timed event strobes.
module prog_mem_exec
  import prog_mem_exec_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_a,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] data,
  input  logic          start,
  input  logic          tick_en,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [5:0]    ev_strobe,
  output logic          tno_valid,
  output logic [47:0]   tno_time,
  output logic [7:0]    dni,
  output logic [7:0]    h,
  output logic [7:0]    min,
  output logic [7:0]    s
);

  state_t          state_r, state_s;
  logic [AW-1:0]   pc_r, pc_s;
  logic [ACCW-1:0] acc_r, acc_s;
  logic [2:0]      cnt_r, cnt_s;
  logic            phase_r, phase_s;
  logic            tno_sel_r, tno_sel_s;
  logic [5:0]      ev_sel_r, ev_sel_s;
  logic            busy_r, busy_s;
  logic            err_r, err_s;
  logic            done_r, done_s;
  logic [5:0]      ev_r, ev_s;
  logic            tnov_r, tnov_s;
  logic [47:0]     tno_time_r, tno_time_s;
  logic [7:0]      dni_r, h_r, min_r, s_r;
  logic            re_s;
  logic [AW-1:0]   raddr_s;
  logic [DW-1:0]   rdata_s;
  logic [7:0]      op_s;

  prog_ram_256x16 u_ram (
    .clk   (clk),
    .we    (we_a),
    .waddr (addr),
    .wdata (data),
    .re    (re_s),
    .raddr (raddr_s),
    .rdata (rdata_s)
  );

  assign op_s = rdata_s[7:0];

  // Interpreter next-state, read request and registered-output next values.
  always_comb begin
    state_s    = state_r;
    pc_s       = pc_r;
    acc_s      = acc_r;
    cnt_s      = cnt_r;
    phase_s    = phase_r;
    tno_sel_s  = tno_sel_r;
    ev_sel_s   = ev_sel_r;
    busy_s     = busy_r;
    err_s      = err_r;
    done_s     = 1'b0;
    ev_s       = 6'd0;
    tnov_s     = 1'b0;
    tno_time_s = tno_time_r;
    re_s       = 1'b0;
    raddr_s    = pc_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_FETCH;
          pc_s    = 8'd0;
          acc_s   = 20'd0;
          err_s   = 1'b0;
          busy_s  = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (pc_r >= TBASE) begin
          err_s   = 1'b1;
          busy_s  = 1'b0;
          state_s = ST_IDLE;
        end else begin
          re_s    = 1'b1;
          pc_s    = pc_r + 8'd1;
          state_s = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (op_s == OP_TNO) begin
          tno_sel_s = 1'b1;
          cnt_s     = TNO_OPERANDS;
          phase_s   = 1'b0;
          state_s   = ST_OPND;
        end else if (is_delay(op_s)) begin
          tno_sel_s = 1'b0;
          cnt_s     = 3'd1;
          phase_s   = 1'b0;
          state_s   = ST_OPND;
        end else if (is_event(op_s)) begin
          ev_sel_s = ev_mask(op_s);
          if (acc_r == 20'd0) begin
            ev_s    = ev_mask(op_s);
            state_s = ST_STROBE;
          end else begin
            state_s = ST_WAIT;
          end
        end else if (op_s == OP_END) begin
          done_s  = 1'b1;
          busy_s  = 1'b0;
          state_s = ST_IDLE;
        end else begin
          err_s   = 1'b1;
          busy_s  = 1'b0;
          state_s = ST_IDLE;
        end
      end
      ST_OPND: begin
        if (!phase_r) begin
          // Issue the operand read; data arrives next cycle.
          if (pc_r >= TBASE) begin
            err_s   = 1'b1;
            busy_s  = 1'b0;
            state_s = ST_IDLE;
          end else begin
            re_s    = 1'b1;
            pc_s    = pc_r + 8'd1;
            phase_s = 1'b1;
          end
        end else begin
          phase_s = 1'b0;
          cnt_s   = cnt_r - 3'd1;
          if (tno_sel_r) begin
            // Shift in so the first operand ends up in the top byte.
            tno_time_s = {tno_time_r[39:0], rdata_s[7:0]};
          end else begin
            acc_s = sat_add(acc_r, rdata_s);
          end
          if (cnt_r == 3'd1) begin
            tnov_s  = tno_sel_r;
            state_s = ST_FETCH;
          end else begin
            state_s = ST_OPND;
          end
        end
      end
      ST_WAIT: begin
        if (tick_en) begin
          acc_s = acc_r - 20'd1;
          if (acc_r == 20'd1) begin
            ev_s    = ev_sel_r;
            state_s = ST_STROBE;
          end else begin
            state_s = ST_WAIT;
          end
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_STROBE: begin
        acc_s   = 20'd0;
        state_s = ST_FETCH;
      end
      default: begin
        busy_s  = 1'b0;
        state_s = ST_IDLE;
      end
    endcase
  end

  // Interpreter state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      pc_r       <= 8'd0;
      acc_r      <= 20'd0;
      cnt_r      <= 3'd0;
      phase_r    <= 1'b0;
      tno_sel_r  <= 1'b0;
      ev_sel_r   <= 6'd0;
      busy_r     <= 1'b0;
      err_r      <= 1'b0;
      done_r     <= 1'b0;
      ev_r       <= 6'd0;
      tnov_r     <= 1'b0;
      tno_time_r <= 48'd0;
    end else begin
      state_r    <= state_s;
      pc_r       <= pc_s;
      acc_r      <= acc_s;
      cnt_r      <= cnt_s;
      phase_r    <= phase_s;
      tno_sel_r  <= tno_sel_s;
      ev_sel_r   <= ev_sel_s;
      busy_r     <= busy_s;
      err_r      <= err_s;
      done_r     <= done_s;
      ev_r       <= ev_s;
      tnov_r     <= tnov_s;
      tno_time_r <= tno_time_s;
    end
  end

  // Time-of-day shadows follow writes to the reserved words directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dni_r <= 8'd0;
      h_r   <= 8'd0;
      min_r <= 8'd0;
      s_r   <= 8'd0;
    end else if (we_a) begin
      case (addr)
        ADDR_DNI: dni_r <= data[7:0];
        ADDR_H:   h_r   <= data[7:0];
        ADDR_MIN: min_r <= data[7:0];
        ADDR_S:   s_r   <= data[7:0];
        default:  dni_r <= dni_r;
      endcase
    end else begin
      dni_r <= dni_r;
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign err       = err_r;
  assign ev_strobe = ev_r;
  assign tno_valid = tnov_r;
  assign tno_time  = tno_time_r;
  assign dni       = dni_r;
  assign h         = h_r;
  assign min       = min_r;
  assign s         = s_r;

endmodule

// File: tb/tb_prog_mem_exec.sv
// Bench for prog_mem_exec: an instruction-level timing model predicts every
// output per cycle after start; a single compare process checks the DUT.
module tb_prog_mem_exec;

  localparam int MAXC = 4096;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we_a = 1'b0;
  logic [7:0]  addr = 8'd0;
  logic [15:0] data = 16'd0;
  logic        start = 1'b0;
  logic        tick_en = 1'b0;
  logic        busy, done, err, tno_valid;
  logic [5:0]  ev_strobe;
  logic [47:0] tno_time;
  logic [7:0]  dni, h, min, s;

  prog_mem_exec dut (
    .clk(clk), .rst_n(rst_n), .we_a(we_a), .addr(addr), .data(data),
    .start(start), .tick_en(tick_en), .busy(busy), .done(done), .err(err),
    .ev_strobe(ev_strobe), .tno_valid(tno_valid), .tno_time(tno_time),
    .dni(dni), .h(h), .min(min), .s(s)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] shadow [0:255];
  bit          exp_busy [MAXC];
  bit          exp_done [MAXC];
  bit          exp_err  [MAXC];
  bit          exp_tnov [MAXC];
  logic [5:0]  exp_ev   [MAXC];
  logic [47:0] exp_tno = 48'd0;
  int          model_end = 0;
  bit          model_err = 1'b0;
  logic [19:0] model_acc = 20'd0;
  int          cyc = 0;
  bit          chk_on = 1'b0;
  int          obs_ev [6];
  int          obs_done = -1;
  int          n_tnov = 0;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit tick_at(input int c, input int div);
    return (c % div) == (div - 1);
  endfunction

  function automatic logic [5:0] ev_of(input logic [7:0] op);
    case (op)
      8'h02:   return 6'b000001;
      8'h03:   return 6'b000010;
      8'h04:   return 6'b000100;
      8'h05:   return 6'b001000;
      8'h06:   return 6'b010000;
      8'h0D:   return 6'b100000;
      default: return 6'b000000;
    endcase
  endfunction

  // Instruction-level model: opcode fetch costs 2 cycles, each operand 2,
  // an armed event waits for acc ticks, strobes, then fetches the next word.
  task automatic build_model(input int div);
    int t, pc, c, n, end_c, sum;
    logic [19:0] acc;
    logic [7:0]  op;
    logic [47:0] tno;
    bit fin, e;
    for (int i = 0; i < MAXC; i++) begin
      exp_ev[i] = 6'd0; exp_done[i] = 1'b0; exp_tnov[i] = 1'b0;
    end
    t = 0; pc = 0; acc = 20'd0; fin = 1'b0; e = 1'b0; end_c = 0; tno = 48'd0;
    while (!fin) begin
      if (t > MAXC - 32) begin
        e = 1'b1; end_c = MAXC - 1; fin = 1'b1;
      end else if (pc >= 250) begin
        e = 1'b1; end_c = t + 1; fin = 1'b1;
      end else begin
        op = shadow[pc][7:0];
        pc++;
        if (op == 8'h01) begin
          for (int i = 0; i < 6; i++) begin
            if (!fin) begin
              if (pc >= 250) begin
                e = 1'b1; end_c = t + 3 + 2 * i; fin = 1'b1;
              end else begin
                tno = {tno[39:0], shadow[pc][7:0]};
                pc++;
              end
            end
          end
          if (!fin) begin
            exp_tnov[t + 14] = 1'b1; exp_tno = tno; t = t + 14;
          end
        end else if ((op >= 8'h07 && op <= 8'h0C) || op == 8'h0E) begin
          if (pc >= 250) begin
            e = 1'b1; end_c = t + 3; fin = 1'b1;
          end else begin
            sum = int'(acc) + int'(shadow[pc]);
            acc = (sum > 1048575) ? 20'hFFFFF : 20'(sum);
            pc++;
            t = t + 4;
          end
        end else if (ev_of(op) != 6'd0) begin
          if (acc == 20'd0) begin
            exp_ev[t + 2] = exp_ev[t + 2] | ev_of(op);
            t = t + 3;
          end else begin
            n = int'(acc);
            c = t + 1;
            while (n > 0 && c < MAXC - 8) begin
              c++;
              if (tick_at(c, div)) n--;
            end
            exp_ev[c + 1] = exp_ev[c + 1] | ev_of(op);
            t = c + 2;
            acc = 20'd0;
          end
        end else if (op == 8'hFF) begin
          exp_done[t + 2] = 1'b1; end_c = t + 2; fin = 1'b1;
        end else begin
          e = 1'b1; end_c = t + 2; fin = 1'b1;
        end
      end
    end
    for (int i = 0; i < MAXC; i++) begin
      exp_busy[i] = (i < end_c);
      exp_err[i]  = e && (i >= end_c);
    end
    model_end = end_c; model_err = e; model_acc = acc;
  endtask

  task automatic write_word(input logic [7:0] a, input logic [15:0] d);
    @(negedge clk);
    we_a = 1'b1; addr = a; data = d; shadow[a] = d;
    @(negedge clk);
    we_a = 1'b0;
  endtask

  // Start the program, drive tick_en with the chosen period, optionally
  // pulse start mid-run and write the word being fetched two cycles before done.
  task automatic run_prog(input int div, input int limit, input int inj_start,
                          input bit coll_en, input logic [7:0] caddr, input logic [15:0] cdata);
    int n, coll_cyc;
    build_model(div);
    n = model_end + 3;
    if (n > limit) n = limit;
    coll_cyc = coll_en ? (model_end - 2) : -1;
    for (int i = 0; i < 6; i++) obs_ev[i] = -1;
    obs_done = -1; n_tnov = 0;
    @(negedge clk);
    start = 1'b1; tick_en = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      cyc = k; chk_on = 1'b1;
      @(negedge clk);
      start = (k == inj_start);
      tick_en = tick_at(k, div);
      we_a = (k == coll_cyc);
      if (k == coll_cyc) begin
        addr = caddr; data = cdata; shadow[caddr] = cdata;
      end
    end
    @(posedge clk);
    chk_on = 1'b0;
    @(negedge clk);
    tick_en = 1'b0; start = 1'b0; we_a = 1'b0;
  endtask

  // Compare process: every post-start cycle against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      check("busy", busy, exp_busy[cyc]);
      check("done", done, exp_done[cyc]);
      check("err", err, exp_err[cyc]);
      check("tno_valid", tno_valid, exp_tnov[cyc]);
      check("ev_strobe", ev_strobe, exp_ev[cyc]);
      if (exp_tnov[cyc]) check("tno_time", tno_time, exp_tno);
      if (tno_valid) n_tnov++;
      for (int i = 0; i < 6; i++) if (ev_strobe[i] && obs_ev[i] < 0) obs_ev[i] = cyc;
      if (done && obs_done < 0) obs_done = cyc;
    end
  end

  logic [15:0] prog_default [28] = '{
    16'h0001, 16'd10, 16'd15, 16'd45, 16'd0, 16'd1, 16'd50,
    16'h0007, 16'd144, 16'h0002,
    16'h0008, 16'd208, 16'h0003,
    16'h000A, 16'd150, 16'h0005,
    16'h0009, 16'd208, 16'h0004,
    16'h000B, 16'd145, 16'h0006,
    16'h000C, 16'd0, 16'h000E, 16'd0, 16'h000D, 16'h00FF
  };

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 48'd0);
    check("rst_done", done, 48'd0);
    check("rst_err", err, 48'd0);
    check("rst_ev", ev_strobe, 48'd0);
    check("rst_tno", tno_time, 48'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Default program plus time words.
    for (int i = 0; i < 28; i++) write_word(8'(i), prog_default[i]);
    write_word(8'd250, 16'hAB0A);
    check("dni_next_edge", dni, 48'd10);
    write_word(8'd251, 16'h120F);
    write_word(8'd252, 16'h002D);
    write_word(8'd253, 16'hFF00);
    check("h", h, 48'd15);
    check("min", min, 48'd45);
    check("s", s, 48'd0);

    // Continuous ticks, with an ignored start pulse mid-run.
    run_prog(1, MAXC, 100, 1'b0, 8'd0, 16'd0);
    check("tno_time_lit", tno_time, 48'h0A0F2D000132);
    check("tno_valid_once", n_tnov, 48'd1);
    check("tnc_cyc", obs_ev[0], 48'd164);
    check("tni_cyc", obs_ev[1], 48'd379);
    check("tki_cyc", obs_ev[3], 48'd536);
    check("tnp_cyc", obs_ev[2], 48'd751);
    check("tkp_cyc", obs_ev[4], 48'd903);
    check("tobm_cyc", obs_ev[5], 48'd914);
    check("done_cyc", obs_done, 48'd917);
    check("err_after_run", err, 48'd0);

    // One tick in four: the TNC wait spans exactly 4*144 cycles.
    run_prog(4, MAXC, -1, 1'b0, 8'd0, 16'd0);
    check("tnc_cyc_div4", obs_ev[0], 48'd596);

    // Overwrite the word being fetched: the old End still executes.
    write_word(8'd0, 16'h0007);
    write_word(8'd1, 16'd5);
    write_word(8'd2, 16'h0002);
    write_word(8'd3, 16'h00FF);
    run_prog(1, MAXC, -1, 1'b1, 8'd3, 16'h0042);
    check("coll_done_cyc", obs_done, 48'd14);
    run_prog(1, MAXC, -1, 1'b0, 8'd0, 16'd0);
    check("coll_new_word_err", err, 48'd1);

    // Unknown opcode after an event; upper byte of an opcode ignored.
    write_word(8'd0, 16'h5A07);
    write_word(8'd1, 16'd2);
    write_word(8'd2, 16'h000D);
    write_word(8'd3, 16'h0042);
    run_prog(1, MAXC, -1, 1'b0, 8'd0, 16'd0);
    check("unk_err", err, 48'd1);
    check("unk_busy", busy, 48'd0);
    check("unk_tobm_cyc", obs_ev[5], 48'd8);
    run_prog(1, MAXC, -1, 1'b0, 8'd0, 16'd0);

    // No End: delays fill up to the reserved words and saturate acc.
    for (int i = 0; i < 250; i = i + 2) begin
      write_word(8'(i), 16'h0007);
      write_word(8'(i + 1), 16'hFFFF);
    end
    run_prog(1, MAXC, -1, 1'b0, 8'd0, 16'd0);
    check("overrun_end_cyc", model_end, 48'd501);
    check("overrun_err", err, 48'd1);
    check("model_acc_sat", model_acc, 48'hFFFFF);
    check("acc_sat", dut.acc_r, model_acc);

    // Reset in the middle of a long wait.
    write_word(8'd0, 16'h0007);
    write_word(8'd1, 16'd200);
    write_word(8'd2, 16'h0002);
    write_word(8'd3, 16'h00FF);
    run_prog(1, 30, 10, 1'b0, 8'd0, 16'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 48'd0);
    check("mid_rst_ev", ev_strobe, 48'd0);
    check("mid_rst_done", done, 48'd0);
    check("mid_rst_err", err, 48'd0);
    check("mid_rst_tno", tno_time, 48'd0);
    check("mid_rst_dni", dni, 48'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("post_rst_done", done, 48'd0);
      check("post_rst_busy", busy, 48'd0);
    end
    tick_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
